// File: rtl/mpif_rx_fifo_reader_if.sv
// FIFO-side and downstream-stream signals of the MPIF RX FIFO reader.
// master = the reader engine, slave = pointer controller / RAM / downstream sink.
interface mpif_rx_fifo_reader_if #(
  parameter int DATAWIDTH = 32
) ();
  logic                 fifoEmpty;
  logic                 fifoPtrsNull;
  logic [DATAWIDTH-1:0] fifoRdData;
  logic                 fifoRead;
  logic                 rdFlush;
  logic                 outValid;
  logic [DATAWIDTH-1:0] outData;
  logic                 outReady;

  modport master (
    input  fifoEmpty, fifoPtrsNull, fifoRdData, outReady,
    output fifoRead, rdFlush, outValid, outData
  );

  modport slave (
    output fifoEmpty, fifoPtrsNull, fifoRdData, outReady,
    input  fifoRead, rdFlush, outValid, outData
  );
endinterface

// File: rtl/mpif_rx_fifo_reader.sv
// Drains the MPIF RX FIFO RAM into a 2-entry skid buffer feeding a valid/ready stream; sequences flushes.
// Latency: first word valid 2 cycles after fifoEmpty falls; 1 word/cycle sustained. Backpressure: reads stop once buffer + in-flight reach 2.
module mpif_rx_fifo_reader #(
  parameter int DATAWIDTH = 32,
  parameter int CNTWIDTH  = 16,
  parameter int FLUSH_MIN = 8
) (
  input  logic                rdClk,
  input  logic                rdHardReset_n,
  input  logic                flushReq,
  output logic                flushDone,
  output logic [CNTWIDTH-1:0] wordCount,
  mpif_rx_fifo_reader_if.master bus
);

  localparam int FCW = $clog2(FLUSH_MIN + 1);
  localparam logic [FCW-1:0] FMIN = FCW'(FLUSH_MIN);

  typedef enum logic { RUN, FLUSH } state_e;

  state_e               state_q, state_d;
  logic                 in_flight_q, in_flight_d;
  logic [1:0]           occ_q, occ_d;
  logic [DATAWIDTH-1:0] head_q, head_d;
  logic [DATAWIDTH-1:0] tail_q, tail_d;
  logic [CNTWIDTH-1:0]  cnt_q, cnt_d;
  logic [FCW-1:0]       fcnt_q, fcnt_d;
  logic                 rd_flush_q, rd_flush_d;
  logic                 flush_done_q, flush_done_d;
  logic                 rd_en;
  logic                 pop;
  logic                 cap;

  assign pop = (occ_q != 2'd0) && bus.outReady;
  assign cap = in_flight_q;

  always_comb begin
    state_d      = state_q;
    in_flight_d  = in_flight_q;
    occ_d        = occ_q;
    head_d       = head_q;
    tail_d       = tail_q;
    cnt_d        = cnt_q;
    fcnt_d       = fcnt_q;
    rd_flush_d   = rd_flush_q;
    flush_done_d = 1'b0;
    rd_en        = 1'b0;
    case (state_q)
      RUN: begin
        if (flushReq) begin
          state_d     = FLUSH;
          occ_d       = 2'd0;
          in_flight_d = 1'b0;
          cnt_d       = '0;
          fcnt_d      = '0;
          rd_flush_d  = 1'b1;
        end else begin
          // A slot freed by this cycle's pop is reusable, which keeps the stream at full rate.
          rd_en = !bus.fifoEmpty &&
                  (({1'b0, occ_q} + {2'b00, in_flight_q}) < (3'd2 + {2'b00, pop}));
          in_flight_d = rd_en;
          if (pop) cnt_d = cnt_q + 1'b1;
          case ({cap, pop})
            2'b10: begin
              if (occ_q == 2'd0) head_d = bus.fifoRdData;
              else               tail_d = bus.fifoRdData;
              occ_d = occ_q + 2'd1;
            end
            2'b01: begin
              head_d = tail_q;
              occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
              if (occ_q == 2'd1) begin
                head_d = bus.fifoRdData;
              end else begin
                head_d = tail_q;
                tail_d = bus.fifoRdData;
              end
            end
            default: ;
          endcase
        end
      end
      default: begin
        in_flight_d = 1'b0;
        if (fcnt_q != FMIN) fcnt_d = fcnt_q + 1'b1;
        if ((fcnt_q == FMIN) && bus.fifoPtrsNull) begin
          flush_done_d = 1'b1;
          // A request landing on the completion cycle chains straight into a fresh flush.
          if (flushReq) begin
            fcnt_d = '0;
          end else begin
            state_d    = RUN;
            rd_flush_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge rdClk or negedge rdHardReset_n) begin
    if (!rdHardReset_n) begin
      state_q      <= RUN;
      in_flight_q  <= 1'b0;
      occ_q        <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
      cnt_q        <= '0;
      fcnt_q       <= '0;
      rd_flush_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_flight_q  <= in_flight_d;
      occ_q        <= occ_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
      fcnt_q       <= fcnt_d;
      rd_flush_q   <= rd_flush_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.fifoRead = rd_en;
  assign bus.rdFlush  = rd_flush_q;
  assign bus.outValid = (occ_q != 2'd0);
  assign bus.outData  = head_q;
  assign flushDone    = flush_done_q;
  assign wordCount    = cnt_q;

endmodule
